// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin bus arbiter, one outstanding transaction
// Fresh requests forward with zero latency; losers and requests during WAIT wait in a per-master slot.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 4
`endif

module bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            m0_req,
  input  logic [`XLEN-1:0]                m0_addr,
  input  logic                            m0_w_rb,
  input  logic [$clog2(`BUS_ACC_CNT)-1:0] m0_acc,
  input  logic [`BUS_WIDTH-1:0]           m0_wdata,
  output logic [`BUS_WIDTH-1:0]           m0_rdata,
  output logic                            m0_resp,
  output logic                            m0_err,
  input  logic                            m1_req,
  input  logic [`XLEN-1:0]                m1_addr,
  input  logic                            m1_w_rb,
  input  logic [$clog2(`BUS_ACC_CNT)-1:0] m1_acc,
  input  logic [`BUS_WIDTH-1:0]           m1_wdata,
  output logic [`BUS_WIDTH-1:0]           m1_rdata,
  output logic                            m1_resp,
  output logic                            m1_err,
  output logic                            bus_req,
  output logic [`XLEN-1:0]                bus_addr,
  output logic                            bus_w_rb,
  output logic [$clog2(`BUS_ACC_CNT)-1:0] bus_acc,
  output logic [`BUS_WIDTH-1:0]           bus_wdata,
  input  logic [`BUS_WIDTH-1:0]           bus_rdata,
  input  logic                            bus_resp,
  output logic                            timeout_flag
);

  localparam int AW = $clog2(`BUS_ACC_CNT);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                      state_q, state_d;
  logic [9:0]                  cnt_q, cnt_d;
  logic                        owner_q, owner_d;
  logic                        last_grant_q, last_grant_d;
  logic                        timeout_flag_q, timeout_flag_d;
  logic [1:0]                  pend_v_q, pend_v_d;
  logic [1:0][`XLEN-1:0]       pend_addr_q, pend_addr_d;
  logic [1:0]                  pend_w_rb_q, pend_w_rb_d;
  logic [1:0][AW-1:0]          pend_acc_q, pend_acc_d;
  logic [1:0][`BUS_WIDTH-1:0]  pend_wdata_q, pend_wdata_d;

  logic [1:0]                  in_req;
  logic [1:0][`XLEN-1:0]       in_addr;
  logic [1:0]                  in_w_rb;
  logic [1:0][AW-1:0]          in_acc;
  logic [1:0][`BUS_WIDTH-1:0]  in_wdata;

  logic [1:0] busy, rq, cand;
  logic       grant_valid, gnt, timeout_hit, done;

  assign in_req   = {m1_req, m0_req};
  assign in_addr  = {m1_addr, m0_addr};
  assign in_w_rb  = {m1_w_rb, m0_w_rb};
  assign in_acc   = {m1_acc, m0_acc};
  assign in_wdata = {m1_wdata, m0_wdata};

  always_comb begin
    // A master with a request still in flight or queued has its extra pulses dropped.
    busy[0]     = pend_v_q[0] | ((state_q == ST_WAIT) & ~owner_q);
    busy[1]     = pend_v_q[1] | ((state_q == ST_WAIT) & owner_q);
    rq          = in_req & ~busy;
    cand        = pend_v_q | rq;
    grant_valid = rstn & (state_q == ST_IDLE) & (|cand);
    gnt         = (&cand) ? ~last_grant_q : cand[1];
    timeout_hit = (state_q == ST_WAIT) & (cnt_q == 10'(TIMEOUT - 1)) & ~bus_resp;
    done        = rstn & (state_q == ST_WAIT) & (bus_resp | timeout_hit);
  end

  always_comb begin
    bus_req   = grant_valid;
    bus_addr  = '0;
    bus_w_rb  = 1'b0;
    bus_acc   = '0;
    bus_wdata = '0;
    if (grant_valid) begin
      bus_addr  = pend_v_q[gnt] ? pend_addr_q[gnt]  : in_addr[gnt];
      bus_w_rb  = pend_v_q[gnt] ? pend_w_rb_q[gnt]  : in_w_rb[gnt];
      bus_acc   = pend_v_q[gnt] ? pend_acc_q[gnt]   : in_acc[gnt];
      bus_wdata = pend_v_q[gnt] ? pend_wdata_q[gnt] : in_wdata[gnt];
    end
  end

  always_comb begin
    m0_resp  = done & ~owner_q;
    m1_resp  = done & owner_q;
    m0_err   = m0_resp & ~bus_resp;
    m1_err   = m1_resp & ~bus_resp;
    m0_rdata = (m0_resp & bus_resp) ? bus_rdata : '0;
    m1_rdata = (m1_resp & bus_resp) ? bus_rdata : '0;
    timeout_flag = timeout_flag_q;
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    timeout_flag_d = timeout_flag_q;
    pend_v_d       = pend_v_q;
    pend_addr_d    = pend_addr_q;
    pend_w_rb_d    = pend_w_rb_q;
    pend_acc_d     = pend_acc_q;
    pend_wdata_d   = pend_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d       = ST_WAIT;
          cnt_d         = '0;
          owner_d       = gnt;
          last_grant_d  = gnt;
          pend_v_d[gnt] = 1'b0;
        end
      end
      default: begin
        cnt_d = cnt_q + 10'd1;
        if (done) begin
          state_d = ST_IDLE;
          if (timeout_hit) timeout_flag_d = 1'b1;
        end
      end
    endcase
    // Any accepted pulse that did not go straight to the bus waits in its slot.
    for (int n = 0; n < 2; n++) begin
      if (rq[n] && !(grant_valid && (gnt == 1'(n)))) begin
        pend_v_d[n]     = 1'b1;
        pend_addr_d[n]  = in_addr[n];
        pend_w_rb_d[n]  = in_w_rb[n];
        pend_acc_d[n]   = in_acc[n];
        pend_wdata_d[n] = in_wdata[n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      owner_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      timeout_flag_q <= 1'b0;
      pend_v_q       <= '0;
      pend_addr_q    <= '0;
      pend_w_rb_q    <= '0;
      pend_acc_q     <= '0;
      pend_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      owner_q        <= owner_d;
      last_grant_q   <= last_grant_d;
      timeout_flag_q <= timeout_flag_d;
      pend_v_q       <= pend_v_d;
      pend_addr_q    <= pend_addr_d;
      pend_w_rb_q    <= pend_w_rb_d;
      pend_acc_q     <= pend_acc_d;
      pend_wdata_q   <= pend_wdata_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter (TIMEOUT=8)
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 4
`endif

module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic m0_req, m0_w_rb, m0_resp, m0_err;
  logic m1_req, m1_w_rb, m1_resp, m1_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [1:0] m0_acc, m1_acc, bus_acc;
  logic bus_req, bus_w_rb, bus_resp, timeout_flag;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_w_rb(m0_w_rb), .m0_acc(m0_acc),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_resp(m0_resp), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_w_rb(m1_w_rb), .m1_acc(m1_acc),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_resp(m1_resp), .m1_err(m1_err),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_w_rb(bus_w_rb), .bus_acc(bus_acc),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_resp(bus_resp),
    .timeout_flag(timeout_flag)
  );

  task automatic quiet();
    m0_req = 0; m1_req = 0; bus_resp = 0; bus_rdata = 32'h0;
  endtask

  // Advance one cycle: inputs change 1ns after the edge, checks follow 2ns later.
  task automatic nxt();
    @(posedge clk);
    #1;
    quiet();
  endtask

  task automatic do_reset();
    nxt(); rstn = 0;
    nxt(); rstn = 1;
  endtask

  task automatic test_reset();
    rstn = 0; quiet();
    m0_addr = 0; m0_w_rb = 0; m0_acc = 0; m0_wdata = 0;
    m1_addr = 0; m1_w_rb = 0; m1_acc = 0; m1_wdata = 0;
    nxt(); nxt();
    m0_req = 1; bus_resp = 1; bus_rdata = 32'hFFFF_FFFF; #2;
    n_chk++;
    if ({bus_req, m0_resp, m1_resp, m0_err, m1_err, m0_rdata, m1_rdata, timeout_flag} !== 71'h0) begin
      n_fail++; $display("FAIL reset_outputs: got req=%b r0=%b r1=%b d0=%h d1=%h tf=%b expected all 0",
                         bus_req, m0_resp, m1_resp, m0_rdata, m1_rdata, timeout_flag);
    end
    nxt(); rstn = 1; #2;
    n_chk++;
    if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_no_pending: got bus_req=%b expected 0", bus_req); end
  endtask

  task automatic test_single_read();
    nxt(); m1_req = 1; m1_addr = 32'h1000_0004; m1_w_rb = 0; m1_acc = 2'd2; #2;
    n_chk++;
    if ({bus_req, bus_addr, bus_w_rb, bus_acc} !== {1'b1, 32'h1000_0004, 1'b0, 2'd2}) begin
      n_fail++; $display("FAIL single_issue: got req=%b addr=%h expected 1 10000004", bus_req, bus_addr);
    end
    nxt(); #2;
    n_chk++;
    if ({bus_req, m1_resp} !== 2'b00) begin n_fail++; $display("FAIL single_wait: got req=%b r1=%b expected 0 0", bus_req, m1_resp); end
    nxt(); bus_resp = 1; bus_rdata = 32'hDEAD_BEEF; #2;
    n_chk++;
    if ({m1_resp, m1_err, m1_rdata, m0_resp, m0_rdata} !== {2'b10, 32'hDEAD_BEEF, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL single_resp: got r1=%b e1=%b d1=%h r0=%b d0=%h expected 1 0 deadbeef 0 0",
                         m1_resp, m1_err, m1_rdata, m0_resp, m0_rdata);
    end
    nxt(); bus_resp = 1; bus_rdata = 32'h1; #2;
    n_chk++;
    if ({m0_resp, m1_resp} !== 2'b00) begin n_fail++; $display("FAIL idle_resp_drop: got r0=%b r1=%b expected 0 0", m0_resp, m1_resp); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    m0_req = 1; m0_addr = 32'hA0; m0_wdata = 32'h11; m0_w_rb = 0;
    m1_req = 1; m1_addr = 32'hB0; m1_wdata = 32'h22; m1_w_rb = 1; #2;
    n_chk++;
    if ({bus_req, bus_addr} !== {1'b1, 32'hA0}) begin n_fail++; $display("FAIL sim_first_m0: got req=%b addr=%h expected 1 a0", bus_req, bus_addr); end
    nxt(); m1_addr = 32'hDEAD; m1_wdata = 32'hDEAD; bus_resp = 1; bus_rdata = 32'h55; #2;
    n_chk++;
    if ({m0_resp, m0_rdata, m1_resp, bus_req} !== {1'b1, 32'h55, 2'b00}) begin
      n_fail++; $display("FAIL sim_m0_resp: got r0=%b d0=%h r1=%b req=%b expected 1 55 0 0", m0_resp, m0_rdata, m1_resp, bus_req);
    end
    nxt(); #2;
    n_chk++;
    if ({bus_req, bus_addr, bus_wdata, bus_w_rb} !== {1'b1, 32'hB0, 32'h22, 1'b1}) begin
      n_fail++; $display("FAIL sim_m1_issue: got req=%b addr=%h wd=%h w=%b expected 1 b0 22 1", bus_req, bus_addr, bus_wdata, bus_w_rb);
    end
    nxt(); bus_resp = 1; bus_rdata = 32'h66; #2;
    n_chk++;
    if ({m1_resp, m1_rdata, m0_resp} !== {1'b1, 32'h66, 1'b0}) begin
      n_fail++; $display("FAIL sim_m1_resp: got r1=%b d1=%h r0=%b expected 1 66 0", m1_resp, m1_rdata, m0_resp);
    end
  endtask

  task automatic test_round_robin();
    for (int r = 0; r < 2; r++) begin
      nxt(); m0_req = 1; m0_addr = 32'h100 + r; m1_req = 1; m1_addr = 32'h200 + r; #2;
      n_chk++;
      if ({bus_req, bus_addr} !== {1'b1, 32'h100 + r}) begin n_fail++; $display("FAIL rr_grant0_%0d: got req=%b addr=%h expected m0", r, bus_req, bus_addr); end
      nxt(); bus_resp = 1; #2;
      n_chk++;
      if ({m0_resp, m1_resp} !== 2'b10) begin n_fail++; $display("FAIL rr_resp0_%0d: got r0=%b r1=%b expected 1 0", r, m0_resp, m1_resp); end
      nxt(); #2;
      n_chk++;
      if ({bus_req, bus_addr} !== {1'b1, 32'h200 + r}) begin n_fail++; $display("FAIL rr_grant1_%0d: got req=%b addr=%h expected m1", r, bus_req, bus_addr); end
      nxt(); bus_resp = 1; #2;
      n_chk++;
      if ({m0_resp, m1_resp} !== 2'b01) begin n_fail++; $display("FAIL rr_resp1_%0d: got r0=%b r1=%b expected 0 1", r, m0_resp, m1_resp); end
    end
  endtask

  task automatic test_timeout();
    nxt(); m0_req = 1; m0_addr = 32'h300; #2;
    for (int c = 1; c <= 8; c++) begin
      nxt(); bus_rdata = 32'hCAFE_F00D; #2;
      if (c < 8) begin
        n_chk++;
        if (m0_resp !== 1'b0) begin n_fail++; $display("FAIL to_early_%0d: got r0=%b expected 0", c, m0_resp); end
      end else begin
        n_chk++;
        if ({m0_resp, m0_err, m0_rdata, m1_resp} !== {2'b11, 32'h0, 1'b0}) begin
          n_fail++; $display("FAIL to_abort: got r0=%b e0=%b d0=%h r1=%b expected 1 1 0 0", m0_resp, m0_err, m0_rdata, m1_resp);
        end
      end
    end
    nxt(); bus_resp = 1; bus_rdata = 32'h77; #2;
    n_chk++;
    if ({m0_resp, m1_resp, timeout_flag} !== 3'b001) begin
      n_fail++; $display("FAIL to_late_resp: got r0=%b r1=%b tf=%b expected 0 0 1", m0_resp, m1_resp, timeout_flag);
    end
    nxt(); m1_req = 1; m1_addr = 32'h400; #2;
    for (int c = 1; c <= 8; c++) begin
      nxt();
      if (c == 8) begin bus_resp = 1; bus_rdata = 32'h88; end
      #2;
    end
    n_chk++;
    if ({m1_resp, m1_err, m1_rdata} !== {2'b10, 32'h88}) begin
      n_fail++; $display("FAIL to_resp_wins: got r1=%b e1=%b d1=%h expected 1 0 88", m1_resp, m1_err, m1_rdata);
    end
  endtask

  task automatic test_capture_wait();
    nxt(); m1_req = 1; m1_addr = 32'h500; m1_w_rb = 0; #2;
    nxt(); m0_req = 1; m0_addr = 32'h600; m0_w_rb = 1; m0_wdata = 32'h1234_5678; #2;
    n_chk++;
    if (bus_req !== 1'b0) begin n_fail++; $display("FAIL cap_no_issue: got req=%b expected 0", bus_req); end
    nxt(); m0_w_rb = 0; m0_wdata = 32'h0; m0_addr = 32'h0; bus_resp = 1; #2;
    n_chk++;
    if ({m1_resp, m0_resp} !== 2'b10) begin n_fail++; $display("FAIL cap_m1_resp: got r1=%b r0=%b expected 1 0", m1_resp, m0_resp); end
    nxt(); #2;
    n_chk++;
    if ({bus_req, bus_addr, bus_w_rb, bus_wdata} !== {1'b1, 32'h600, 1'b1, 32'h1234_5678}) begin
      n_fail++; $display("FAIL cap_issue: got req=%b addr=%h w=%b wd=%h expected 1 600 1 12345678", bus_req, bus_addr, bus_w_rb, bus_wdata);
    end
    nxt(); bus_resp = 1; #2;
  endtask

  task automatic test_violation();
    nxt(); m1_req = 1; m1_addr = 32'h700; #2;
    nxt(); m1_req = 1; m1_addr = 32'h7FF; #2;
    nxt(); bus_resp = 1; #2;
    nxt(); #2;
    n_chk++;
    if (bus_req !== 1'b0) begin n_fail++; $display("FAIL viol_ignored: got req=%b addr=%h expected 0", bus_req, bus_addr); end
  endtask

  task automatic test_reset_mid_wait();
    nxt(); m0_req = 1; m0_addr = 32'h800; #2;
    nxt(); m1_req = 1; m1_addr = 32'h900; #2;
    nxt(); rstn = 0; #2;
    n_chk++;
    if ({m0_resp, m1_resp, bus_req} !== 3'b000) begin n_fail++; $display("FAIL rst_wait_quiet: got r0=%b r1=%b req=%b expected 0", m0_resp, m1_resp, bus_req); end
    nxt(); rstn = 1; bus_resp = 1; bus_rdata = 32'h99; #2;
    n_chk++;
    if ({m0_resp, m1_resp, bus_req, timeout_flag} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_wait_drop: got r0=%b r1=%b req=%b tf=%b expected 0", m0_resp, m1_resp, bus_req, timeout_flag);
    end
    nxt(); m1_req = 1; m1_addr = 32'hA00; #2;
    n_chk++;
    if ({bus_req, bus_addr} !== {1'b1, 32'hA00}) begin n_fail++; $display("FAIL rst_wait_next: got req=%b addr=%h expected 1 a00", bus_req, bus_addr); end
    nxt(); bus_resp = 1; bus_rdata = 32'hAB; #2;
    n_chk++;
    if ({m1_resp, m1_rdata} !== {1'b1, 32'hAB}) begin n_fail++; $display("FAIL rst_wait_resp: got r1=%b d1=%h expected 1 ab", m1_resp, m1_rdata); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_round_robin();
    test_timeout();
    test_capture_wait();
    test_violation();
    test_reset_mid_wait();
    nxt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: bus cycles allowed per transaction before abort; legal range 2..1023.
REQ-002 SHALL have ports: clk  input  1  clock; rstn  input  1  reset, synchronous, active-low.
REQ-003 SHALL have, for N in {0,1} (0=ifetch, 1=lsu), these master ports:
- mN_req  input  1  request pulse
- mN_addr  input  `XLEN  address
- mN_w_rb  input  1  1=write
- mN_acc  input  $clog2(`BUS_ACC_CNT)  access size
- mN_wdata  input  `BUS_WIDTH  write data
- mN_rdata  output  `BUS_WIDTH  read data
- mN_resp  output  1  completion pulse
- mN_err  output  1  timeout, valid with mN_resp
REQ-004 SHALL have these bus-side ports, toward the bus decoder:
- bus_req  output  1  request pulse
- bus_addr  output  `XLEN  address
- bus_w_rb  output  1  1=write
- bus_acc  output  $clog2(`BUS_ACC_CNT)  access size
- bus_wdata  output  `BUS_WIDTH  write data
- bus_rdata  input  `BUS_WIDTH  read data
- bus_resp  input  1  completion pulse
REQ-005 SHALL have: timeout_flag  output  1  sticky, set on any timeout.

Function
REQ-006 SHALL implement states IDLE and WAIT; at most one bus transaction outstanding.
REQ-007 Each master SHALL issue a new mN_req only after mN_resp for its previous request. A violating pulse SHALL be ignored.
REQ-008 SHALL hold one pending entry per master: valid bit plus addr, w_rb, acc and wdata. An mN_req not forwarded in the same cycle SHALL be captured there.
REQ-009 Candidates in IDLE SHALL be each master with a valid pending entry or mN_req=1.
REQ-010 In IDLE with exactly one candidate, SHALL assert bus_req for one cycle, driving bus_addr/w_rb/acc/wdata from that request, and enter WAIT.
- A new mN_req SHALL be forwarded combinationally in the cycle it arrives, with zero latency.
- A pending entry SHALL be forwarded from its buffer.
REQ-011 With two candidates, SHALL grant the master not granted last (round-robin). last_grant resets to 1, so master 0 wins the first tie. The loser stays pending or is captured.
REQ-012 Outside a bus_req cycle, bus_req SHALL be 0. Other bus outputs are don't-care but SHALL be stable and deterministic.
REQ-013 In WAIT, every incoming mN_req SHALL be captured into its pending entry.
REQ-014 In WAIT, a bus_resp=1 cycle SHALL do all of the following in that same cycle, combinationally:
- assert m{owner}_resp=1 and m{owner}_err=0
- drive m{owner}_rdata=bus_rdata
- select IDLE for the next cycle; a pending request issues no earlier than the following cycle.
REQ-015 The non-owner's mN_resp SHALL be 0, and its mN_rdata SHALL be 0.
REQ-016 The WAIT counter SHALL behave as follows:
- It clears on entry to WAIT and increments each WAIT cycle.
- If it reaches TIMEOUT-1 without bus_resp, SHALL assert m{owner}_resp=1, m{owner}_err=1, m{owner}_rdata=0, set timeout_flag and return to IDLE.
- bus_resp in that same cycle SHALL take precedence, giving a normal completion.
REQ-017 A bus_resp received in IDLE SHALL be dropped, with no mN_resp.
REQ-018 The owner SHALL be released on resp or timeout; ownership SHALL never change within WAIT.
REQ-019 The pending entry of the granted master SHALL clear in its grant cycle.

Reset
REQ-020 With rstn=0 at a clk edge, the following SHALL be reset:
- state=IDLE, counter=0, last_grant=1
- both pending valid bits=0, timeout_flag=0
REQ-021 During reset cycles, bus_req and all mN_resp/mN_err SHALL be 0, and rdata outputs SHALL be 0.
REQ-022 Reset during WAIT SHALL abandon the transaction with no mN_resp; a later bus_resp SHALL be dropped per REQ-017.

Verification
REQ-023 Single read: m1_req, addr=0x10000004, idle bus -> bus_req same cycle with addr=0x10000004; bus_resp 2 cycles later with rdata=0xDEADBEEF -> m1_resp=1, m1_rdata=0xDEADBEEF, m0_resp=0.
REQ-024 Simultaneous requests after reset: m0_req & m1_req in one cycle -> m0 granted, m1 pending. After bus_resp -> one idle cycle, then bus_req with m1's addr/wdata.
REQ-025 Round-robin: both masters repeatedly request in the same cycle -> grants alternate 0,1,0,1; no master waits more than one transaction.
REQ-026 Timeout: TIMEOUT=8, no bus_resp -> 8th WAIT cycle gives owner resp=1, err=1, rdata=0, timeout_flag=1. A bus_resp one cycle later is dropped.
REQ-027 Capture during WAIT: m0_req with w_rb=1, wdata=0x12345678 while m1 is outstanding -> bus_req for m0 carries w_rb=1, wdata=0x12345678 after m1 completes.
REQ-028 Reset mid-WAIT: rstn=0 for 1 cycle -> no mN_resp, pendings cleared. A subsequent bus_resp produces no mN_resp; next request is served normally.
